// File: rtl/node_join_ctrl_pkg.sv
// node_join_ctrl_pkg
// Shared system-flit types for the node join controller:
//   - hdr_code_t   : 8-bit system header codes
//   - join_state_t : join controller state encoding
//   - field_msb()  : MSB position of ID field k in a system payload,
//                    fields packed MSB-first, NODE_ID_W bits each
package node_join_ctrl_pkg;

    localparam int HDR_W = 8;

    typedef enum logic [HDR_W-1:0] {
        HDR_NOPE       = 8'd0,
        HDR_HEARTBEAT  = 8'd1,
        HDR_RESET      = 8'd2,
        HDR_PARENT_REQ = 8'd3,
        HDR_PARENT_ACK = 8'd4,
        HDR_JOIN_REQ   = 8'd5,
        HDR_JOIN_ACK   = 8'd6
    } hdr_code_t;

    typedef enum logic [2:0] {
        JS_IDLE      = 3'd0,
        JS_SEND_PREQ = 3'd1,
        JS_WAIT_PACK = 3'd2,
        JS_SEND_JREQ = 3'd3,
        JS_WAIT_JACK = 3'd4,
        JS_JOINED    = 3'd5,
        JS_FAILED    = 3'd6
    } join_state_t;

    function automatic int field_msb(input int k, input int node_id_w, input int payload_w);
        return payload_w - 1 - k * node_id_w;
    endfunction

endpackage

// File: rtl/node_join_ctrl_if.sv
// node_join_ctrl_if
// System-flit link between the join controller and the node's flit
// encoder (TX) / decoder (RX). Signal suffixes are from the controller's
// point of view.
//   tx_valid_o / tx_ready_i          : TX valid/ready handshake
//   tx_header_o / tx_payload_o       : TX system header and payload
//   rx_valid_i                       : one-cycle RX qualifier, no backpressure
//   rx_header_i / rx_payload_i       : RX system header and payload
// Modports: master = controller, slave = encoder/decoder side.
interface node_join_ctrl_if
    import node_join_ctrl_pkg::*;
#(
    parameter int PAYLOAD_W = 64
);
    logic                 tx_valid_o;
    logic                 tx_ready_i;
    logic [HDR_W-1:0]     tx_header_o;
    logic [PAYLOAD_W-1:0] tx_payload_o;
    logic                 rx_valid_i;
    logic [HDR_W-1:0]     rx_header_i;
    logic [PAYLOAD_W-1:0] rx_payload_i;

    modport master (
        output tx_valid_o, tx_header_o, tx_payload_o,
        input  tx_ready_i, rx_valid_i, rx_header_i, rx_payload_i
    );

    modport slave (
        input  tx_valid_o, tx_header_o, tx_payload_o,
        output tx_ready_i, rx_valid_i, rx_header_i, rx_payload_i
    );
endinterface

// File: rtl/node_id_lfsr.sv
// node_id_lfsr
// Free-running right-shift Galois LFSR producing the random child ID.
// Maximal-length taps are tabulated for widths 4..16. The state never
// reaches zero because the seed is forced nonzero and the step is invertible.
//   clk   : clock
//   rst_n : asynchronous active-low reset, loads the seed
//   value : current LFSR state
module node_id_lfsr #(
    parameter int          WIDTH = 8,
    parameter int unsigned SEED  = 'hA5
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] value
);

    function automatic logic [31:0] tap_mask(input int w);
        case (w)
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_B400;
            // Untabulated width: plain rotation, still never zero.
            default: return 32'h1 << (w - 1);
        endcase
    endfunction

    localparam logic [31:0]      TAPS32  = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] TAPS    = TAPS32[WIDTH-1:0];
    localparam logic [31:0]      SEED32  = SEED;
    localparam logic [WIDTH-1:0] SEED_T  = SEED32[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_NZ = (SEED_T == '0) ? WIDTH'(1) : SEED_T;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= SEED_NZ;
        end else if (value[0]) begin
            value <= (value >> 1) ^ TAPS;
        end else begin
            value <= value >> 1;
        end
    end

endmodule

// File: rtl/node_join_ctrl.sv
// node_join_ctrl
// Per-node join controller. Acquires a parent ID and a child ID in two
// request/acknowledge phases (PARENT_REQ/PARENT_ACK, JOIN_REQ/JOIN_ACK),
// each guarded by a timeout with bounded retries. A received RESET flit
// returns the block to idle from any state.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start_i      : begin a join (honoured in IDLE, JOINED, FAILED)
//   bus          : system-flit TX/RX link (master side)
//   busy_o       : join in progress
//   joined_o     : join complete, IDs valid
//   failed_o     : retries exhausted
//   parent_id_o  : parent ID from PARENT_ACK
//   child_id_o   : child ID from JOIN_ACK
//   global_id_o  : global ID from PARENT_ACK
module node_join_ctrl
    import node_join_ctrl_pkg::*;
#(
    parameter int          NODE_ID_W      = 8,
    parameter int          PAYLOAD_W      = 64,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter int          MAX_RETRY      = 4,
    parameter int unsigned LFSR_SEED      = 'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    node_join_ctrl_if.master     bus,
    output logic                 busy_o,
    output logic                 joined_o,
    output logic                 failed_o,
    output logic [NODE_ID_W-1:0] parent_id_o,
    output logic [NODE_ID_W-1:0] child_id_o,
    output logic [NODE_ID_W-1:0] global_id_o
);

    localparam logic [2:0] S_IDLE      = JS_IDLE;
    localparam logic [2:0] S_SEND_PREQ = JS_SEND_PREQ;
    localparam logic [2:0] S_WAIT_PACK = JS_WAIT_PACK;
    localparam logic [2:0] S_SEND_JREQ = JS_SEND_JREQ;
    localparam logic [2:0] S_WAIT_JACK = JS_WAIT_JACK;
    localparam logic [2:0] S_JOINED    = JS_JOINED;
    localparam logic [2:0] S_FAILED    = JS_FAILED;

    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    localparam int F0_MSB = field_msb(0, NODE_ID_W, PAYLOAD_W);
    localparam int F1_MSB = field_msb(1, NODE_ID_W, PAYLOAD_W);
    localparam int F2_MSB = field_msb(2, NODE_ID_W, PAYLOAD_W);

    logic [2:0]           state_q;
    logic [TMO_W-1:0]     tmo_q;
    logic [RETRY_W-1:0]   retry_q;
    logic                 tx_valid_q;
    logic                 joined_q;
    logic                 failed_q;
    logic [NODE_ID_W-1:0] rand_q;
    logic [NODE_ID_W-1:0] parent_q;
    logic [NODE_ID_W-1:0] child_q;
    logic [NODE_ID_W-1:0] global_q;
    logic [NODE_ID_W-1:0] lfsr_value;

    logic [HDR_W-1:0]     tx_header;
    logic [PAYLOAD_W-1:0] tx_payload;

    node_id_lfsr #(
        .WIDTH (NODE_ID_W),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .value (lfsr_value)
    );

    logic [NODE_ID_W-1:0] rx_f0, rx_f1, rx_f2;
    logic                 rx_reset, pack_hit, jack_hit, tx_fire, timeout, can_retry;
    logic                 unused_rx_lsb;

    assign rx_f0 = bus.rx_payload_i[F0_MSB -: NODE_ID_W];
    assign rx_f1 = bus.rx_payload_i[F1_MSB -: NODE_ID_W];
    assign rx_f2 = bus.rx_payload_i[F2_MSB -: NODE_ID_W];
    // Payload LSBs below the third field carry nothing for this block.
    assign unused_rx_lsb = &{1'b0, bus.rx_payload_i};

    assign rx_reset  = bus.rx_valid_i && (bus.rx_header_i == HDR_RESET);
    assign pack_hit  = bus.rx_valid_i && (bus.rx_header_i == HDR_PARENT_ACK);
    // Only an ACK echoing our random ID and chosen parent belongs to us.
    assign jack_hit  = bus.rx_valid_i && (bus.rx_header_i == HDR_JOIN_ACK)
                       && (rx_f0 == rand_q) && (rx_f1 == parent_q);
    assign tx_fire   = tx_valid_q && bus.tx_ready_i;
    assign timeout   = (tmo_q == TMO_LAST);
    assign can_retry = (retry_q < RETRY_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tmo_q      <= '0;
            retry_q    <= '0;
            tx_valid_q <= 1'b0;
            joined_q   <= 1'b0;
            failed_q   <= 1'b0;
            rand_q     <= '0;
            parent_q   <= '0;
            child_q    <= '0;
            global_q   <= '0;
        end else if (rx_reset) begin
            state_q    <= S_IDLE;
            tmo_q      <= '0;
            retry_q    <= '0;
            tx_valid_q <= 1'b0;
            joined_q   <= 1'b0;
            failed_q   <= 1'b0;
            rand_q     <= '0;
            parent_q   <= '0;
            child_q    <= '0;
            global_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_JOINED, S_FAILED: begin
                    if (start_i) begin
                        state_q    <= S_SEND_PREQ;
                        tx_valid_q <= 1'b1;
                        joined_q   <= 1'b0;
                        failed_q   <= 1'b0;
                        retry_q    <= '0;
                    end
                end
                S_SEND_PREQ, S_SEND_JREQ: begin
                    if (tx_fire) begin
                        state_q    <= (state_q == S_SEND_PREQ) ? S_WAIT_PACK : S_WAIT_JACK;
                        tx_valid_q <= 1'b0;
                        tmo_q      <= '0;
                    end
                end
                S_WAIT_PACK: begin
                    if (pack_hit) begin
                        parent_q   <= rx_f0;
                        global_q   <= rx_f2;
                        rand_q     <= lfsr_value;
                        retry_q    <= '0;
                        state_q    <= S_SEND_JREQ;
                        tx_valid_q <= 1'b1;
                    end else if (timeout) begin
                        if (can_retry) begin
                            retry_q    <= retry_q + 1'b1;
                            state_q    <= S_SEND_PREQ;
                            tx_valid_q <= 1'b1;
                        end else begin
                            state_q  <= S_FAILED;
                            failed_q <= 1'b1;
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_WAIT_JACK: begin
                    if (jack_hit) begin
                        child_q  <= rx_f2;
                        joined_q <= 1'b1;
                        state_q  <= S_JOINED;
                    end else if (timeout) begin
                        if (can_retry) begin
                            // Each retransmission carries a freshly drawn ID.
                            rand_q     <= lfsr_value;
                            retry_q    <= retry_q + 1'b1;
                            state_q    <= S_SEND_JREQ;
                            tx_valid_q <= 1'b1;
                        end else begin
                            state_q  <= S_FAILED;
                            failed_q <= 1'b1;
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Header and payload derive only from registers that are frozen while
    // the flit is offered, so they stay stable under backpressure.
    always_comb begin
        tx_header  = HDR_NOPE;
        tx_payload = '0;
        if (tx_valid_q) begin
            if (state_q == S_SEND_JREQ) begin
                tx_header                      = HDR_JOIN_REQ;
                tx_payload[F0_MSB -: NODE_ID_W] = rand_q;
                tx_payload[F1_MSB -: NODE_ID_W] = parent_q;
            end else begin
                tx_header = HDR_PARENT_REQ;
            end
        end
    end

    assign bus.tx_valid_o   = tx_valid_q;
    assign bus.tx_header_o  = tx_header;
    assign bus.tx_payload_o = tx_payload;

    assign busy_o      = (state_q != S_IDLE) && (state_q != S_JOINED) && (state_q != S_FAILED);
    assign joined_o    = joined_q;
    assign failed_o    = failed_q;
    assign parent_id_o = parent_q;
    assign child_id_o  = child_q;
    assign global_id_o = global_q;

endmodule

// File: tb/tb_node_join_ctrl.sv
// tb_node_join_ctrl
// Directed bench for node_join_ctrl: an 8/64-bit instance (short timeout,
// two retries) and a 12/48-bit instance for field-width generalisation.
module tb_node_join_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int xfers_a = 0;

    logic       start_a, busy_a, joined_a, failed_a;
    logic [7:0] parent_a, child_a, global_a;
    logic        start_b, busy_b, joined_b, failed_b;
    logic [11:0] parent_b, child_b, global_b;

    node_join_ctrl_if #(.PAYLOAD_W(64)) ifa ();
    node_join_ctrl_if #(.PAYLOAD_W(48)) ifb ();

    node_join_ctrl #(
        .NODE_ID_W(8), .PAYLOAD_W(64), .TIMEOUT_CYCLES(16), .MAX_RETRY(2), .LFSR_SEED('hA5)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_a), .bus(ifa),
        .busy_o(busy_a), .joined_o(joined_a), .failed_o(failed_a),
        .parent_id_o(parent_a), .child_id_o(child_a), .global_id_o(global_a)
    );

    node_join_ctrl #(
        .NODE_ID_W(12), .PAYLOAD_W(48), .TIMEOUT_CYCLES(16), .MAX_RETRY(2), .LFSR_SEED('hA5)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .bus(ifb),
        .busy_o(busy_b), .joined_o(joined_b), .failed_o(failed_b),
        .parent_id_o(parent_b), .child_id_o(child_b), .global_id_o(global_b)
    );

    always @(posedge clk) begin
        if (ifa.tx_valid_o && ifa.tx_ready_i) xfers_a <= xfers_a + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rx_a(input logic [7:0] h, input logic [63:0] p);
        ifa.rx_valid_i = 1'b1; ifa.rx_header_i = h; ifa.rx_payload_i = p;
        tick();
        ifa.rx_valid_i = 1'b0; ifa.rx_header_i = '0; ifa.rx_payload_i = '0;
    endtask

    task automatic rx_b(input logic [7:0] h, input logic [47:0] p);
        ifb.rx_valid_i = 1'b1; ifb.rx_header_i = h; ifb.rx_payload_i = p;
        tick();
        ifb.rx_valid_i = 1'b0; ifb.rx_header_i = '0; ifb.rx_payload_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  r1, r2;
        logic [11:0] rb;
        int n, x0;
        start_a = 1'b0; start_b = 1'b0;
        ifa.tx_ready_i = 1'b1; ifa.rx_valid_i = 1'b0; ifa.rx_header_i = '0; ifa.rx_payload_i = '0;
        ifb.tx_ready_i = 1'b1; ifb.rx_valid_i = 1'b0; ifb.rx_header_i = '0; ifb.rx_payload_i = '0;
        #1 rst_n = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_valid",  ifa.tx_valid_o, 0);
        check("rst_busy",   busy_a, 0);
        check("rst_joined", joined_a, 0);
        check("rst_failed", failed_a, 0);
        check("rst_parent", parent_a, 0);
        check("rst_child",  child_a, 0);
        check("rst_global", global_a, 0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy_a, 0);

        // Happy path
        start_a = 1'b1; tick(); start_a = 1'b0;
        check("preq_valid",   ifa.tx_valid_o, 1);
        check("preq_hdr",     ifa.tx_header_o, 3);
        check("preq_payload", ifa.tx_payload_o, 0);
        check("preq_busy",    busy_a, 1);
        tick();
        check("preq_done", ifa.tx_valid_o, 0);
        start_a = 1'b1; tick(); start_a = 1'b0;
        check("start_ignored_valid", ifa.tx_valid_o, 0);
        check("start_ignored_busy",  busy_a, 1);
        rx_a(8'd4, 64'h1200_7700_0000_0000);
        check("jreq_valid",  ifa.tx_valid_o, 1);
        check("jreq_hdr",    ifa.tx_header_o, 5);
        check("jreq_parent", ifa.tx_payload_o[55:48], 8'h12);
        check("jreq_lsb",    ifa.tx_payload_o[47:0], 0);
        r1 = ifa.tx_payload_o[63:56];
        check("jreq_rand_nz", r1 != 8'h00, 1);
        check("pack_parent", parent_a, 8'h12);
        check("pack_global", global_a, 8'h77);
        tick();
        check("jreq_done", ifa.tx_valid_o, 0);
        rx_a(8'd6, {r1, 8'h12, 8'h34, 40'h0});
        check("joined",        joined_a, 1);
        check("joined_busy",   busy_a, 0);
        check("joined_parent", parent_a, 8'h12);
        check("joined_child",  child_a, 8'h34);
        check("joined_global", global_a, 8'h77);
        check("joined_valid",  ifa.tx_valid_o, 0);

        // Backpressure, then timeout/retry to FAILED
        x0 = xfers_a;
        ifa.tx_ready_i = 1'b0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        check("bp_joined_clr", joined_a, 0);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", ifa.tx_valid_o, 1);
            check("bp_hdr",   ifa.tx_header_o, 3);
            check("bp_pay",   ifa.tx_payload_o, 0);
            tick();
        end
        ifa.tx_ready_i = 1'b1;
        tick();
        check("bp_drop", ifa.tx_valid_o, 0);
        n = 0;
        do begin tick(); n++; end while (!ifa.tx_valid_o && n < 40);
        check("retry1_gap", n, 16);
        check("retry1_hdr", ifa.tx_header_o, 3);
        tick();
        n = 0;
        do begin tick(); n++; end while (!ifa.tx_valid_o && n < 40);
        check("retry2_gap", n, 16);
        tick();
        n = 0;
        do begin tick(); n++; end while (!failed_a && n < 40);
        check("fail_gap",   n, 16);
        check("fail_flag",  failed_a, 1);
        check("fail_busy",  busy_a, 0);
        check("fail_valid", ifa.tx_valid_o, 0);
        repeat (20) tick();
        check("preq_xfers", xfers_a - x0, 3);

        // Wrong random ID ignored, retry with fresh ID, ACK on timeout cycle
        start_a = 1'b1; tick(); start_a = 1'b0;
        check("restart_failed_clr", failed_a, 0);
        tick();
        rx_a(8'd4, 64'h2100_5500_0000_0000);
        check("jr2_valid", ifa.tx_valid_o, 1);
        r1 = ifa.tx_payload_o[63:56];
        check("jr2_rand_nz", r1 != 8'h00, 1);
        check("jr2_parent", parent_a, 8'h21);
        check("jr2_global", global_a, 8'h55);
        tick();
        rx_a(8'd6, {r1 ^ 8'h01, 8'h21, 8'h44, 40'h0});
        check("wrong_rand_joined", joined_a, 0);
        n = 1;
        while (!ifa.tx_valid_o && n < 40) begin tick(); n++; end
        check("jretry_gap", n, 16);
        check("jretry_hdr", ifa.tx_header_o, 5);
        r2 = ifa.tx_payload_o[63:56];
        check("jretry_rand_nz",  r2 != 8'h00, 1);
        check("jretry_fresh",    r2 != r1, 1);
        check("jretry_parent",   ifa.tx_payload_o[55:48], 8'h21);
        tick();
        repeat (15) tick();
        x0 = xfers_a;
        rx_a(8'd6, {r2, 8'h21, 8'h56, 40'h0});
        check("edge_ack_joined", joined_a, 1);
        check("edge_ack_child",  child_a, 8'h56);
        check("edge_ack_valid",  ifa.tx_valid_o, 0);
        repeat (20) tick();
        check("edge_ack_no_retx", xfers_a - x0, 0);

        // RESET flit while waiting for JOIN_ACK
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick();
        rx_a(8'd4, 64'h3100_6600_0000_0000);
        tick();
        check("wj_busy",  busy_a, 1);
        check("wj_valid", ifa.tx_valid_o, 0);
        rx_a(8'd2, 64'h0);
        check("sreset_valid",  ifa.tx_valid_o, 0);
        check("sreset_busy",   busy_a, 0);
        check("sreset_joined", joined_a, 0);
        check("sreset_failed", failed_a, 0);
        check("sreset_parent", parent_a, 0);
        check("sreset_child",  child_a, 0);
        check("sreset_global", global_a, 0);

        // Asynchronous reset while a flit is offered
        ifa.tx_ready_i = 1'b0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        check("arst_pre_valid", ifa.tx_valid_o, 1);
        #2 rst_n = 1'b0;
        #1 check("arst_valid", ifa.tx_valid_o, 0);
        check("arst_busy", busy_a, 0);
        tick();
        rst_n = 1'b1;
        ifa.tx_ready_i = 1'b1;

        // 12-bit IDs in a 48-bit payload
        tick();
        start_b = 1'b1; tick(); start_b = 1'b0;
        check("b_preq_valid", ifb.tx_valid_o, 1);
        check("b_preq_hdr",   ifb.tx_header_o, 3);
        tick();
        rx_b(8'd4, 48'h123_000_789_000);
        check("b_jreq_hdr",    ifb.tx_header_o, 5);
        check("b_jreq_parent", ifb.tx_payload_o[35:24], 12'h123);
        check("b_jreq_lsb",    ifb.tx_payload_o[23:0], 0);
        rb = ifb.tx_payload_o[47:36];
        check("b_jreq_rand_nz", rb != 12'h000, 1);
        check("b_pack_global",  global_b, 12'h789);
        tick();
        rx_b(8'd6, {rb, 12'h123, 12'hABC, 12'h000});
        check("b_joined", joined_b, 1);
        check("b_parent", parent_b, 12'h123);
        check("b_child",  child_b, 12'hABC);
        check("b_global", global_b, 12'h789);
        check("b_busy",   busy_b, 0);
        check("b_failed", failed_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/node_join_ctrl.md
# node_join_ctrl

Per-node join controller for the collision-avoidance mesh. It acquires a parent and a child ID over system flits in two phases: PARENT_REQUEST/PARENT_ACK, then JOIN_REQUEST/JOIN_ACK. Each wait has a timeout and bounded retries, and a received S_RESET forces the block back to idle. It sits between the node's system-flit encoder (TX) and decoder (RX). It generalises the fixed 8-bit ID / 64-bit payload system message layout to parametrised widths.

## Interface

Parameters:
- NODE_ID_W, 8, width of every node ID field.
- PAYLOAD_W, 64, system payload width; must be ≥ 3*NODE_ID_W.
- TIMEOUT_CYCLES, 1024, number of wait cycles before a retry; ≥ 2.
- MAX_RETRY, 4, retransmissions allowed per phase after the first send.
- LFSR_SEED, 'hA5, nonzero seed for the random child-ID LFSR, truncated to NODE_ID_W.

Ports:
- clk  in  1  clock; single domain.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  pulse; begins a join. Honoured only in IDLE, FAILED or JOINED.
- tx_valid_o  out  1  system flit offered.
- tx_ready_i  in  1  encoder accepts the flit.
- tx_header_o  out  8  system header code.
- tx_payload_o  out  PAYLOAD_W  system payload.
- rx_valid_i  in  1  decoded system flit present; one-cycle qualifier, no backpressure.
- rx_header_i  in  8  received header.
- rx_payload_i  in  PAYLOAD_W  received payload.
- busy_o  out  1  controller is in any state other than IDLE, JOINED or FAILED.
- joined_o  out  1  join complete; IDs are valid.
- failed_o  out  1  retries exhausted.
- parent_id_o  out  NODE_ID_W  registered parent ID.
- child_id_o  out  NODE_ID_W  assigned ID for this node.
- global_id_o  out  NODE_ID_W  global ID taken from PARENT_ACK.

## Operation

- Header codes: NOPE=0, HEARTBEAT=1, RESET=2, PARENT_REQ=3, PARENT_ACK=4, JOIN_REQ=5, JOIN_ACK=6.
- Payload fields are packed MSB-first. Field k occupies bits [PAYLOAD_W-1-k*NODE_ID_W -: NODE_ID_W]. Unused LSBs are driven to 0 on TX and ignored on RX.
  - PARENT_ACK fields: parent_id, child_id, global_id.
  - JOIN_REQ fields: random_child_id, parent_id.
  - JOIN_ACK fields: random_child_id, parent_id, child_id.
- States:
  - IDLE → SEND_PREQ on start_i.
  - SEND_PREQ → WAIT_PACK on a tx handshake.
  - WAIT_PACK → SEND_JREQ on a valid PARENT_ACK. This latches parent_id and global_id. The PARENT_ACK child_id is ignored.
  - SEND_JREQ → WAIT_JACK on a tx handshake.
  - WAIT_JACK → JOINED on a JOIN_ACK whose random_child_id and parent_id both match the stored values. This latches child_id. A JOIN_ACK with non-matching fields is ignored.
  - WAIT_x timeout: if retry_cnt < MAX_RETRY, increment retry_cnt and return to SEND_x. Otherwise go to FAILED.
  - JOINED / FAILED → SEND_PREQ on start_i. This clears joined_o / failed_o and the retry count.
- retry_cnt clears on entry to each SEND phase from the previous phase, so each phase gets MAX_RETRY retries.
- random_child_id:
  - Free-running Galois LFSR of NODE_ID_W bits; never zero.
  - Sampled on every entry to SEND_JREQ, including retries, and held until the next sample.
- rx_header_i == RESET with rx_valid_i in any state: go to IDLE and clear joined_o, failed_o, all IDs and the retry count. This takes priority over every other event.
- Received flits of any other header, or flits arriving in a state that does not expect them, are dropped.

## Timing

- Reset values: all outputs 0, state IDLE, LFSR = LFSR_SEED.
- TX handshake:
  - tx_valid_o asserts the cycle after entering SEND_x.
  - tx_header_o and tx_payload_o stay stable while tx_valid_o=1 and tx_ready_i=0.
  - The transfer happens when tx_valid_o and tx_ready_i are both high at a clock edge.
  - tx_valid_o deasserts the cycle after the transfer.
  - tx_valid_o never drops without a transfer, except on RESET or rst_n.
- Timeout counter:
  - Loads 0 on the handshake edge and increments each cycle in WAIT_x.
  - The timeout fires when the counter reaches TIMEOUT_CYCLES-1, i.e. TIMEOUT_CYCLES cycles after the handshake.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- A matching ACK in the same cycle as the timeout wins; no retry occurs.
- A matching ACK advances state at the next edge. Latched IDs and joined_o are visible in the cycle after the ACK.
- start_i while busy_o=1 is ignored.
- rst_n assertion mid-handshake takes effect immediately; tx_valid_o drops asynchronously.

## Structure

- Extend the shared system-types package with:
  - header code constants;
  - a parametrisable field-offset function: field_msb(k, NODE_ID_W, PAYLOAD_W);
  - join state enum join_state_t.
- One sub-module, node_id_lfsr (parameters: width, seed; ports: clk, rst_n, value). Taps are tabulated for widths 4–16.
- Everything else stays flat in node_join_ctrl.

## Test plan

- Happy path, NODE_ID_W=8, PAYLOAD_W=64, tx_ready_i tied 1:
  - start_i pulse → PARENT_REQ sent.
  - Inject PARENT_ACK {0x12,0x00,0x77} → JOIN_REQ carries {rand,0x12}.
  - Reply JOIN_ACK {rand,0x12,0x34} → joined_o=1, parent=0x12, child=0x34, global=0x77.
- Backpressure: hold tx_ready_i=0 for 5 cycles → tx_valid_o held with stable header/payload. Exactly one transfer, timeout starts only after it.
- Timeout/retry, TIMEOUT_CYCLES=16, MAX_RETRY=2, no RX → PARENT_REQ sent 3 times, 16 cycles apart after each handshake. Then failed_o=1 and busy_o=0.
- JOIN_ACK with a wrong random_child_id → ignored, timeout retry. The retry JOIN_REQ carries a fresh nonzero random ID.
- ACK arriving on the exact timeout cycle → advances, no retransmission. S_RESET in WAIT_JACK → IDLE next cycle with all outputs 0.
- Width generalisation, NODE_ID_W=12, PAYLOAD_W=48 → fields decoded at bits [47:36], [35:24] and [23:12]. Happy path completes.
